desc_diff_streamer: RTL

Producer side of the descriptor-matching datapath. For one query descriptor it reads the query and every scene descriptor from synchronous RAMs and computes the sum of absolute differences (SAD) per scene feature. It streams one `(o_diff, o_indx)` pair per scene feature into the best/second-best ratio-test comparator, then waits for the comparator's match-finish pulse before reporting done. It sits between the descriptor buffers and the comparator, one instance per match engine.

---
 rtl/desc_diff_streamer_if.sv | 38 +++
 rtl/desc_diff_streamer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/desc_diff_streamer_if.sv
// Signal bundle between the descriptor RAMs, the SAD streamer and the ratio-test comparator.
interface desc_diff_streamer_if #(
  parameter int DESC_LEN = 128,
  parameter int ELEM_W   = 8,
  parameter int DIFF_W   = 17,
  parameter int IDX_W    = 10,
  parameter int NUM_W    = 11
);
  localparam int EW = $clog2(DESC_LEN);

  // Handshake: o_valid is a one-cycle strobe with no per-beat backpressure; the consumer must
  // take (o_diff, o_indx, o_last) in the cycle it is seen. Throttling is only via i_stall, which
  // takes effect at the next descriptor boundary. i_match_finish is a one-cycle pulse closing the job.
  logic                  istart;
  logic [NUM_W-1:0]      fnum_scene;
  logic                  i_stall;
  logic                  i_match_finish;
  logic [EW-1:0]         q_addr;
  logic [ELEM_W-1:0]     q_data;
  logic [IDX_W+EW-1:0]   s_addr;
  logic [ELEM_W-1:0]     s_data;
  logic [DIFF_W-1:0]     o_diff;
  logic [IDX_W-1:0]      o_indx;
  logic                  o_valid;
  logic                  o_last;
  logic                  o_busy;
  logic                  o_done;

  modport master (
    input  istart, fnum_scene, i_stall, i_match_finish, q_data, s_data,
    output q_addr, s_addr, o_diff, o_indx, o_valid, o_last, o_busy, o_done
  );

  modport slave (
    output istart, fnum_scene, i_stall, i_match_finish, q_data, s_data,
    input  q_addr, s_addr, o_diff, o_indx, o_valid, o_last, o_busy, o_done
  );
endinterface

// File: rtl/desc_diff_streamer.sv
// Streams one saturated SAD per scene descriptor against a single query descriptor,
// then waits for the comparator's finish pulse before signalling done.
module desc_diff_streamer #(
  parameter int DESC_LEN = 128,
  parameter int ELEM_W   = 8,
  parameter int DIFF_W   = 17,
  parameter int IDX_W    = 10,
  parameter int NUM_W    = 11
) (
  input  logic                 iclk,
  input  logic                 irst,
  desc_diff_streamer_if.master bus,
  output logic [2:0]           state_dbg
);
  localparam int EW = $clog2(DESC_LEN);
  localparam int AW = DIFF_W + 1;
  localparam logic [EW-1:0] ELEM_LAST = EW'(DESC_LEN - 1);
  localparam logic [31:0]   MAX_SCENES = 32'(2 ** IDX_W);
  localparam logic [AW:0]   SAT_CAP = (AW + 1)'(1) << DIFF_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state;
  logic [EW-1:0]     elem;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  last_idx;
  logic              drain_cnt;

  logic              tag_v;
  logic [EW-1:0]     tag_elem;
  logic [IDX_W-1:0]  tag_idx;
  logic              tag_last;

  logic [AW-1:0]     acc;
  logic [AW-1:0]     acc_base;
  logic [AW:0]       acc_sum;
  logic [AW-1:0]     acc_nxt;
  logic [DIFF_W-1:0] diff_nxt;
  logic [ELEM_W-1:0] adiff;

  logic [DIFF_W-1:0] diff_r;
  logic [IDX_W-1:0]  indx_r;
  logic              valid_r;
  logic              last_r;

  logic              scene_clamp;
  logic [NUM_W-1:0]  num_m1;
  logic [IDX_W-1:0]  last_idx_nxt;

  // Counts above 2^IDX_W clamp, so the last index is then all-ones.
  assign scene_clamp  = 32'(bus.fnum_scene) > MAX_SCENES;
  assign num_m1       = bus.fnum_scene - NUM_W'(1);
  assign last_idx_nxt = scene_clamp ? '1 : IDX_W'(num_m1);

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state     <= S_IDLE;
      elem      <= '0;
      idx       <= '0;
      last_idx  <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.istart) begin
            elem     <= '0;
            idx      <= '0;
            last_idx <= last_idx_nxt;
            state    <= (bus.fnum_scene == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          elem <= elem + EW'(1);
          if (elem == ELEM_LAST) begin
            idx <= idx + IDX_W'(1);
            if (idx == last_idx) begin
              state     <= S_DRAIN;
              drain_cnt <= 1'b0;
            end else if (bus.i_stall) begin
              state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!bus.i_stall) state <= S_RUN;
        end
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.i_match_finish) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 1: tag travels alongside the RAM read so it lines up with q_data/s_data.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      tag_v    <= 1'b0;
      tag_elem <= '0;
      tag_idx  <= '0;
      tag_last <= 1'b0;
    end else begin
      tag_v    <= (state == S_RUN);
      tag_elem <= elem;
      tag_idx  <= idx;
      tag_last <= (idx == last_idx);
    end
  end

  always_comb begin
    adiff    = (bus.q_data >= bus.s_data) ? (bus.q_data - bus.s_data)
                                          : (bus.s_data - bus.q_data);
    acc_base = (tag_elem == '0) ? '0 : acc;
    acc_sum  = {1'b0, acc_base} + (AW + 1)'(adiff);
    // Pin the accumulator at 2^DIFF_W once exceeded so it can never wrap back into range.
    acc_nxt  = (acc_sum > SAT_CAP) ? AW'(SAT_CAP) : acc_sum[AW-1:0];
    diff_nxt = acc_nxt[DIFF_W] ? '1 : acc_nxt[DIFF_W-1:0];
  end

  // Stage 2: accumulate and emit on the final element of each descriptor.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      acc     <= '0;
      diff_r  <= '0;
      indx_r  <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      if (tag_v) begin
        acc <= acc_nxt;
        if (tag_elem == ELEM_LAST) begin
          diff_r  <= diff_nxt;
          indx_r  <= tag_idx;
          valid_r <= 1'b1;
          last_r  <= tag_last;
        end
      end
    end
  end

  assign bus.q_addr  = elem;
  assign bus.s_addr  = {idx, elem};
  assign bus.o_diff  = diff_r;
  assign bus.o_indx  = indx_r;
  assign bus.o_valid = valid_r;
  assign bus.o_last  = last_r;
  assign bus.o_busy  = (state != S_IDLE);
  assign bus.o_done  = (state == S_DONE);
  assign state_dbg   = state;

  a_valid_strobe: assert property (@(posedge iclk) disable iff (!irst) bus.o_valid |=> !bus.o_valid);
  a_done_strobe:  assert property (@(posedge iclk) disable iff (!irst) bus.o_done |=> !bus.o_done);
  a_last_valid:   assert property (@(posedge iclk) disable iff (!irst) bus.o_last |-> bus.o_valid);
endmodule
